// File: rtl/traffic_phase_timer.sv
// Multi-phase countdown timer: N programmable phase durations, prescaled ticks,
// cyclic or single-pass sequencing with hold/stop/start control.
module traffic_phase_timer #(
  parameter  int WIDTH       = 8,
  parameter  int NUM_PHASES  = 4,
  parameter  int PRESCALE    = 1,
  parameter  int DEFAULT_DUR = 10,
  localparam int PW          = $clog2(NUM_PHASES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [PW-1:0]    start_phase_i,
  input  logic             stop_i,
  input  logic             hold_i,
  input  logic             cyclic_i,
  input  logic             cfg_we_i,
  input  logic [PW-1:0]    cfg_phase_i,
  input  logic [WIDTH-1:0] cfg_dur_i,
  output logic [PW-1:0]    phase_o,
  output logic [WIDTH-1:0] remaining_o,
  output logic             timeout_o,
  output logic             done_o,
  output logic             running_o
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam int               PSW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSW-1:0]   PS_LAST    = PSW'(PRESCALE - 1);
  localparam logic [PW-1:0]    LAST_PHASE = PW'(NUM_PHASES - 1);
  localparam logic [PW:0]      NP         = (PW + 1)'(NUM_PHASES);
  localparam logic [WIDTH-1:0] DUR_RST    = WIDTH'(DEFAULT_DUR);

  state_t           state_q;
  logic [PW-1:0]    phase_q;
  logic [WIDTH-1:0] remaining_q;
  logic             timeout_q;
  logic             done_q;
  logic [PSW-1:0]   presc_q;
  logic [WIDTH-1:0] dur [NUM_PHASES];

  // One register per phase; an out-of-range cfg_phase matches no entry.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PHASES; gi++) begin : g_dur
      logic [WIDTH-1:0] dur_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dur_q <= DUR_RST;
        end else if (cfg_we_i && (cfg_phase_i == PW'(gi))) begin
          dur_q <= cfg_dur_i;
        end
      end
      assign dur[gi] = dur_q;
    end
  endgenerate

  function automatic logic [WIDTH-1:0] eff(input logic [WIDTH-1:0] d);
    return (d == '0) ? WIDTH'(1) : d;
  endfunction

  logic          start_ok;
  logic          tick;
  logic          last_phase;
  logic [PW-1:0] next_phase;

  assign start_ok   = start_i && ({1'b0, start_phase_i} < NP);
  assign tick       = (presc_q == PS_LAST);
  assign last_phase = (phase_q == LAST_PHASE);
  assign next_phase = last_phase ? '0 : phase_q + PW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      remaining_q <= '0;
      timeout_q   <= 1'b0;
      done_q      <= 1'b0;
      presc_q     <= '0;
    end else begin
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      if (stop_i) begin
        state_q     <= IDLE;
        remaining_q <= '0;
        presc_q     <= '0;
      end else if (start_ok) begin
        state_q     <= RUN;
        phase_q     <= start_phase_i;
        remaining_q <= eff(dur[start_phase_i]);
        presc_q     <= '0;
      end else if (state_q == RUN && !hold_i) begin
        if (!tick) begin
          presc_q <= presc_q + PSW'(1);
        end else begin
          presc_q <= '0;
          if (remaining_q > WIDTH'(1)) begin
            remaining_q <= remaining_q - WIDTH'(1);
          end else begin
            timeout_q <= 1'b1;
            // Reads of dur see the pre-edge value, so a same-cycle write loses to the load.
            if (!last_phase || cyclic_i) begin
              phase_q     <= next_phase;
              remaining_q <= eff(dur[next_phase]);
            end else begin
              done_q      <= 1'b1;
              remaining_q <= '0;
              state_q     <= IDLE;
            end
          end
        end
      end
    end
  end

  assign phase_o     = phase_q;
  assign remaining_o = remaining_q;
  assign timeout_o   = timeout_q;
  assign done_o      = done_q;
  assign running_o   = (state_q == RUN);

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed bench: a PRESCALE=1 and a PRESCALE=4 instance share all inputs;
// expected values are hand-computed cycle counts.
module tb_traffic_phase_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, hold, cyclic, cfg_we;
  logic [1:0] start_phase, cfg_phase;
  logic [7:0] cfg_dur;

  logic [1:0] phase, phase4;
  logic [7:0] rem, rem4;
  logic       timeout, done, running;
  logic       timeout4, done4, running4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  traffic_phase_timer #(.WIDTH(8), .NUM_PHASES(4), .PRESCALE(1), .DEFAULT_DUR(10)) u_dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .start_phase_i(start_phase),
    .stop_i(stop), .hold_i(hold), .cyclic_i(cyclic), .cfg_we_i(cfg_we),
    .cfg_phase_i(cfg_phase), .cfg_dur_i(cfg_dur), .phase_o(phase),
    .remaining_o(rem), .timeout_o(timeout), .done_o(done), .running_o(running)
  );

  traffic_phase_timer #(.WIDTH(8), .NUM_PHASES(4), .PRESCALE(4), .DEFAULT_DUR(10)) u_dut_p4 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .start_phase_i(start_phase),
    .stop_i(stop), .hold_i(hold), .cyclic_i(cyclic), .cfg_we_i(cfg_we),
    .cfg_phase_i(cfg_phase), .cfg_dur_i(cfg_dur), .phase_o(phase4),
    .remaining_o(rem4), .timeout_o(timeout4), .done_o(done4), .running_o(running4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] p, input logic [7:0] d);
    cfg_we = 1'b1; cfg_phase = p; cfg_dur = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] p);
    start = 1'b1; start_phase = p;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 0; stop = 0; hold = 0; cyclic = 1; cfg_we = 0;
    start_phase = 0; cfg_phase = 0; cfg_dur = 0;
    step(2);
    check_eq("rst phase", phase, 0);
    check_eq("rst remaining", rem, 0);
    check_eq("rst running", running, 0);
    check_eq("rst timeout", timeout, 0);
    rst_n = 1'b1;
    step();

    // Defaults, cyclic: timeout every 10 cycles, phase 0,1,2,3,0
    do_start(0);
    check_eq("cyc start rem", rem, 10);
    for (int p = 1; p <= 4; p++) begin
      step(9);
      check_eq($sformatf("cyc pre-end rem p%0d", p), rem, 1);
      check_eq($sformatf("cyc pre-end timeout p%0d", p), timeout, 0);
      step();
      check_eq($sformatf("cyc timeout p%0d", p), timeout, 1);
      check_eq($sformatf("cyc phase p%0d", p), phase, p % 4);
      check_eq($sformatf("cyc reload p%0d", p), rem, 10);
      check_eq($sformatf("cyc running p%0d", p), running, 1);
    end
    do_stop();
    check_eq("stop running", running, 0);
    check_eq("stop rem", rem, 0);
    check_eq("stop phase kept", phase, 0);
    check_eq("stop no timeout", timeout, 0);

    // Single pass with dur={3,0,5,2}: done 11 cycles after start
    cfg_write(0, 3); cfg_write(1, 0); cfg_write(2, 5); cfg_write(3, 2);
    cyclic = 0;
    do_start(0);
    check_eq("sp start rem", rem, 3);
    step(3);
    check_eq("sp p1 phase", phase, 1);
    check_eq("sp p1 rem (zero dur)", rem, 1);
    check_eq("sp p1 timeout", timeout, 1);
    step();
    check_eq("sp p2 phase", phase, 2);
    check_eq("sp p2 rem", rem, 5);
    step(5);
    check_eq("sp p3 phase", phase, 3);
    check_eq("sp p3 rem", rem, 2);
    step();
    check_eq("sp pre-done", done, 0);
    step();
    check_eq("sp done", done, 1);
    check_eq("sp done timeout", timeout, 1);
    check_eq("sp done running", running, 0);
    check_eq("sp done phase", phase, 3);
    check_eq("sp done rem", rem, 0);
    step();
    check_eq("sp done one-cycle", done, 0);
    check_eq("sp timeout one-cycle", timeout, 0);

    // PRESCALE=4 instance with dur[0]=2: first timeout 8 cycles after start
    cfg_write(0, 2);
    do_start(0);
    check_eq("ps start rem", rem4, 2);
    step(3);
    check_eq("ps rem before tick", rem4, 2);
    step();
    check_eq("ps rem after tick", rem4, 1);
    step(3);
    check_eq("ps pre-timeout", timeout4, 0);
    step();
    check_eq("ps timeout", timeout4, 1);
    check_eq("ps phase", phase4, 1);
    check_eq("ps reload rem", rem4, 1);
    do_stop();

    // Hold for 7 cycles at remaining=5 delays the phase end by 7
    cyclic = 1;
    do_start(2);
    check_eq("hold start rem", rem, 5);
    hold = 1'b1;
    step(7);
    check_eq("hold frozen rem", rem, 5);
    check_eq("hold frozen phase", phase, 2);
    hold = 1'b0;
    step(4);
    check_eq("hold post rem", rem, 1);
    check_eq("hold post no timeout", timeout, 0);
    step();
    check_eq("hold end timeout", timeout, 1);
    check_eq("hold end phase", phase, 3);
    do_stop();

    // Mid-phase write of dur[1]; same-cycle write+load of dur[0]
    cfg_write(1, 6);
    do_start(1);
    step(2);
    check_eq("wr rem before", rem, 4);
    cfg_we = 1'b1; cfg_phase = 1; cfg_dur = 9;
    step();
    cfg_we = 1'b0;
    check_eq("wr rem unaffected", rem, 3);
    step(3);
    check_eq("wr cur phase ends", timeout, 1);
    check_eq("wr next phase", phase, 2);
    step(6);
    check_eq("wr p3 last tick", rem, 1);
    cfg_we = 1'b1; cfg_phase = 0; cfg_dur = 7;
    step();
    cfg_we = 1'b0;
    check_eq("wr same-cycle phase", phase, 0);
    check_eq("wr same-cycle old dur", rem, 2);
    step(2);
    check_eq("wr p1 revisit phase", phase, 1);
    check_eq("wr p1 new dur", rem, 9);
    step(9);
    check_eq("wr p1 lasts 9", phase, 2);
    step(7);
    check_eq("wr p0 new dur", rem, 7);

    // stop and start together: stop wins
    start = 1'b1; start_phase = 1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check_eq("stop+start running", running, 0);
    check_eq("stop+start rem", rem, 0);
    check_eq("stop+start timeout", timeout, 0);

    // restart at phase 2 mid-run
    do_start(0);
    step(2);
    do_start(2);
    check_eq("restart phase", phase, 2);
    check_eq("restart rem", rem, 5);
    check_eq("restart running", running, 1);

    // asynchronous reset mid-run, then durations back to default
    step(2);
    rst_n = 1'b0;
    #1;
    check_eq("arst phase", phase, 0);
    check_eq("arst rem", rem, 0);
    check_eq("arst running", running, 0);
    check_eq("arst p4 running", running4, 0);
    step();
    rst_n = 1'b1;
    do_start(2);
    check_eq("arst dur2 default", rem, 10);
    do_start(0);
    check_eq("arst dur0 default", rem, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_phase_timer.md
# traffic_phase_timer

Multi-phase countdown timer for the traffic-light controller, generalising the two-phase (green/yellow) timer to N programmable phases. Durations are run-time configurable, counting is gated by an internal prescaler, and the block runs in cyclic or single-pass mode with hold/stop control. It sits between the light-sequencing FSM, which consumes `phase` and `timeout`, and the configuration/register logic, which drives `cfg_*`.

## Interface
- `WIDTH`, 8: width of duration registers and countdown counter.
- `NUM_PHASES`, 4: number of phases (≥2). `PW = $clog2(NUM_PHASES)`.
- `PRESCALE`, 1: clk cycles per count tick (≥1).
- `DEFAULT_DUR`, 10: reset value of every duration register.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin/restart counting at `start_phase`.
- `start_phase`  in  PW  phase loaded on `start`.
- `stop`  in  1  abort and return to IDLE.
- `hold`  in  1  freeze counting while high.
- `cyclic`  in  1  1 = wrap last phase to phase 0; 0 = end in IDLE after last phase.
- `cfg_we`  in  1  duration write strobe.
- `cfg_phase`  in  PW  phase index for the write.
- `cfg_dur`  in  WIDTH  duration in ticks.
- `phase`  out  PW  current phase.
- `remaining`  out  WIDTH  ticks left in the current phase.
- `timeout`  out  1  one-cycle pulse on each phase end.
- `done`  out  1  one-cycle pulse when a single pass completes.
- `running`  out  1  high in RUN state.

## Operation
- Reset values: state IDLE; `phase`=0, `remaining`=0, `timeout`=0, `done`=0, `running`=0; prescaler=0; all `dur[i]`=DEFAULT_DUR.
- States: IDLE and RUN.
- Control priority per cycle: `stop` > `start` > tick processing.
- `stop`, from any state: go to IDLE, set `remaining`=0, keep `phase`, clear the prescaler. No `timeout` or `done` pulse.
- `start`, from IDLE or RUN: set `phase`=`start_phase` and `remaining`=eff(`dur[start_phase]`), clear the prescaler, go to RUN.
- `start_phase` ≥ NUM_PHASES: the start is ignored.
- eff(d) = (d==0) ? 1 : d. A zero duration lasts one tick.
- RUN with `hold`=0:
  - The prescaler counts 0..PRESCALE-1. A tick occurs on the cycle where it equals PRESCALE-1, and the prescaler then wraps to 0.
  - On a tick with `remaining`>1: decrement `remaining`.
  - On a tick with `remaining`==1: this is a phase end. Assert `timeout`.
  - Phase end, not last phase, or last phase with `cyclic`=1: next = (phase==NUM_PHASES-1) ? 0 : phase+1. Load `remaining`=eff(`dur[next]`).
  - Phase end, last phase with `cyclic`=0: assert `done` together with `timeout`, set `remaining`=0, go to IDLE. `phase` stays NUM_PHASES-1.
- RUN with `hold`=1: prescaler, `remaining` and `phase` are frozen and no ticks occur. `stop` and `start` still act.
- Configuration writes:
  - `cfg_we` writes `dur[cfg_phase]` on the clock edge.
  - `cfg_phase` ≥ NUM_PHASES: the write is ignored.
  - A write never alters the running `remaining`. The new value applies from the next load of that phase.
  - A write and a load of the same phase in the same cycle: the load uses the old value.
- `cyclic` is sampled at each phase end, so it may change mid-run.
- Arithmetic is unsigned WIDTH-bit. `remaining` never underflows, since it is always reloaded at 1.

## Timing
- All outputs are registered.
- `running` = (state==RUN).
- `start` sampled at edge t0: `phase` and `remaining`=D are visible after t0.
- With PRESCALE=1, `remaining` steps D, D-1, …, 1 on successive edges. Each phase therefore lasts eff(D)×PRESCALE cycles when `hold` is not asserted.
- `timeout` is high for exactly one cycle. That cycle coincides with the first cycle showing the new `phase` and reloaded `remaining`, or with IDLE on single-pass end.
- `done` behaves the same way and is only ever high together with `timeout`.
- Reset asserted mid-run: all outputs return to their reset values immediately (asynchronous), and the duration registers return to DEFAULT_DUR.

## Test plan
- Defaults, NUM_PHASES=4, PRESCALE=1, `cyclic`=1, start at phase 0 -> `timeout` pulses every 10 cycles; `phase` steps 0,1,2,3,0; `running` stays 1.
- Program dur={3,0,5,2}, `cyclic`=0, start at phase 0 -> phase lengths 3,1,5,2 cycles. `done` and `timeout` are high together 11 cycles after start; state is IDLE with `phase`=3 and `remaining`=0.
- PRESCALE=4, dur[0]=2 -> `remaining` decrements every 4 cycles; first `timeout` 8 cycles after start.
- `hold` high for 7 cycles while `remaining`=5 -> `remaining` stays 5. The phase end is delayed by exactly 7 cycles.
- Write dur[1]=9 while in phase 1 with `remaining`=4 -> the current phase still ends after 4 ticks; the next visit to phase 1 lasts 9 ticks.
- Same-cycle and mid-run conditions:
  - `stop` and `start` in the same cycle -> IDLE, `remaining`=0, no pulse.
  - `start` with `start_phase`=2 mid-run -> `phase`=2, `remaining`=dur[2] on the next cycle.
  - `rst_n` low mid-run -> all outputs 0 and durations back to 10.
